// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with a per-grant hold limit.
// A grant lasts until the holder signals done, drops its request, or has
// held for MAX_HOLD cycles; every grant is followed by at least one idle cycle.
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       valid
);

    localparam int unsigned N_REQ  = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned HOLD_W = 4;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [IDX_W-1:0]    gnt_idx_q, gnt_idx_d;
    logic                valid_q, valid_d;

    logic [IDX_W-1:0]    sel_idx;
    logic                sel_found;
    logic [IDX_W-1:0]    cand;
    logic                release_c;

    // Find the first requester at or after ptr (mod 8); lower offsets override.
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        cand      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr_q + IDX_W'(k);
            if (req[cand]) begin
                sel_idx   = cand;
                sel_found = 1'b1;
            end
        end
    end

    // Any release condition ends the grant; several at once still release once.
    assign release_c = done | ~req[gnt_idx_q] | (hold_cnt_q == HOLD_LAST);

    // Next-state, pointer, hold counter and registered output computation.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        gnt_idx_d  = gnt_idx_q;
        valid_d    = valid_q;
        unique case (state_q)
            IDLE: begin
                hold_cnt_d = '0;
                if (sel_found) begin
                    state_d   = GRANT;
                    gnt_d     = N_REQ'(1) << sel_idx;
                    gnt_idx_d = sel_idx;
                    valid_d   = 1'b1;
                end
            end
            GRANT: begin
                if (release_c) begin
                    state_d    = IDLE;
                    ptr_d      = gnt_idx_q + IDX_W'(1);
                    hold_cnt_d = '0;
                    gnt_d      = '0;
                    gnt_idx_d  = '0;
                    valid_d    = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything without a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            gnt_idx_q  <= gnt_idx_d;
            valid_q    <= valid_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_q;
    assign valid   = valid_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed scenarios plus random traffic, two instances
// (MAX_HOLD=15 and MAX_HOLD=4) checked against a behavioural arbitration model.
module tb_rr_arbiter8;

    logic       clk;
    logic       reset;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt_a, gnt_b;
    logic [2:0] gnt_idx_a, gnt_idx_b;
    logic       valid_a, valid_b;

    int n_cmp;
    int n_bad;

    // Model: current holder (-1 = none), next search start, cycles held so far.
    int m_hold [2];
    int m_ptr  [2];
    int m_cnt  [2];
    int m_lim  [2];

    rr_arbiter8 #(.MAX_HOLD(15)) u_dut15 (
        .clk(clk), .reset(reset), .req(req), .done(done),
        .gnt(gnt_a), .gnt_idx(gnt_idx_a), .valid(valid_a)
    );

    rr_arbiter8 #(.MAX_HOLD(4)) u_dut4 (
        .clk(clk), .reset(reset), .req(req), .done(done),
        .gnt(gnt_b), .gnt_idx(gnt_idx_b), .valid(valid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int u = 0; u < 2; u++) begin
            m_hold[u] = -1;
            m_ptr[u]  = 0;
            m_cnt[u]  = 0;
        end
    endtask

    task automatic m_update(input int u);
        bit found;
        int i;
        if (m_hold[u] < 0) begin
            found = 0;
            for (int k = 0; k < 8; k++) begin
                i = (m_ptr[u] + k) % 8;
                if (!found && req[i]) begin
                    found     = 1;
                    m_hold[u] = i;
                    m_cnt[u]  = 1;
                end
            end
        end else if (done || !req[m_hold[u]] || m_cnt[u] >= m_lim[u]) begin
            m_ptr[u]  = (m_hold[u] + 1) % 8;
            m_hold[u] = -1;
        end else begin
            m_cnt[u] = m_cnt[u] + 1;
        end
    endtask

    task automatic compare_all(input string tag);
        logic [7:0] e_gnt;
        logic [2:0] e_idx;
        logic       e_vld;
        for (int u = 0; u < 2; u++) begin
            e_gnt = (m_hold[u] < 0) ? 8'h00 : (8'h01 << m_hold[u]);
            e_idx = (m_hold[u] < 0) ? 3'd0 : 3'(m_hold[u]);
            e_vld = (m_hold[u] >= 0);
            if (u == 0) begin
                check({tag, "_gnt15"}, 32'(gnt_a), 32'(e_gnt));
                check({tag, "_idx15"}, 32'(gnt_idx_a), 32'(e_idx));
                check({tag, "_vld15"}, 32'(valid_a), 32'(e_vld));
            end else begin
                check({tag, "_gnt4"}, 32'(gnt_b), 32'(e_gnt));
                check({tag, "_idx4"}, 32'(gnt_idx_b), 32'(e_idx));
                check({tag, "_vld4"}, 32'(valid_b), 32'(e_vld));
            end
        end
    endtask

    // One clock: model sees the inputs present at the edge, outputs checked 1ns later.
    task automatic step(input string tag);
        @(posedge clk);
        if (reset) m_reset();
        else begin
            m_update(0);
            m_update(1);
        end
        #1;
        compare_all(tag);
    endtask

    // Reset pulse between edges; outputs must clear before any clock edge.
    task automatic pulse_reset(input string tag);
        #2 reset = 1'b1;
        m_reset();
        #1;
        compare_all(tag);
        #1 reset = 1'b0;
    endtask

    initial begin
        int         n_grants;
        logic [7:0] prev_a;
        logic       exp_v4 [6];
        logic [2:0] exp_i4 [6];

        n_cmp = 0;
        n_bad = 0;
        m_lim[0] = 15;
        m_lim[1] = 4;
        m_reset();

        // Reset state
        reset = 1'b1;
        req   = 8'h00;
        done  = 1'b0;
        #3;
        compare_all("reset");
        @(negedge clk) reset = 1'b0;
        step("idle_noreq");

        // Single requester 0 granted after one edge
        req = 8'h01;
        step("r030");
        check("r030_gnt", 32'(gnt_a), 32'h01);
        check("r030_vld", 32'(valid_a), 32'h1);

        // All requesting, done pulsed per grant: order 0..7,0 with gaps
        req = 8'h00;
        step("r031_pre");
        pulse_reset("r031_rst");
        req      = 8'hFF;
        n_grants = 0;
        prev_a   = 8'h00;
        for (int c = 0; c < 40 && n_grants < 9; c++) begin
            done = (m_hold[0] >= 0);
            step("r031");
            if (valid_a) begin
                check("r031_order", 32'(gnt_idx_a), 32'(n_grants % 8));
                check("r031_gap", 32'(prev_a), 32'h00);
                n_grants++;
            end
            prev_a = gnt_a;
        end
        check("r031_count", 32'(n_grants), 32'd9);
        done = 1'b0;

        // Grant to 6, release (ptr=7), then 0x41 wraps to requester 0
        pulse_reset("r032_rst");
        req = 8'h40;
        step("r032_g6");
        check("r032_idx6", 32'(gnt_idx_a), 32'd6);
        req = 8'h00;
        step("r032_rel");
        req = 8'h41;
        step("r032_wrap");
        check("r032_idx0", 32'(gnt_idx_a), 32'd0);
        check("r032_vld", 32'(valid_a), 32'h1);

        // Hold limit 4: requester 0 for 4 cycles, one idle, then requester 1
        pulse_reset("r033_rst");
        exp_v4 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        exp_i4 = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
        req = 8'h03;
        for (int c = 0; c < 6; c++) begin
            step("r033");
            check("r033_vld4", 32'(valid_b), 32'(exp_v4[c]));
            check("r033_idx4", 32'(gnt_idx_b), 32'(exp_i4[c]));
        end

        // Mid-grant reset drops grant at once; 0x24 then goes to 2
        pulse_reset("r034_rst0");
        req = 8'h20;
        step("r034_g5");
        check("r034_idx5", 32'(gnt_idx_a), 32'd5);
        step("r034_hold");
        pulse_reset("r034_mid");
        check("r034_gnt0", 32'(gnt_a), 32'h00);
        check("r034_vld0", 32'(valid_a), 32'h0);
        req = 8'h24;
        step("r034_next");
        check("r034_idx2", 32'(gnt_idx_a), 32'd2);

        // done and dropped request together for holder 3: one release, ptr=4
        pulse_reset("r035_rst");
        req = 8'h08;
        step("r035_g3");
        check("r035_idx3", 32'(gnt_idx_a), 32'd3);
        done = 1'b1;
        req  = 8'h00;
        step("r035_rel");
        done = 1'b0;
        req  = 8'h18;
        step("r035_next");
        check("r035_idx4", 32'(gnt_idx_a), 32'd4);

        // Random traffic with occasional mid-run resets
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(99) < 30) req = 8'($urandom);
            done = ($urandom_range(7) == 0);
            if ($urandom_range(199) == 0) pulse_reset("rnd_rst");
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
